// File: rtl/channel_pkg.sv
// Shared constants and FSM state type for the Channel product path.
// CHANNEL_ACC_SAT_EN selects saturating row accumulation in channel_row_accum.
package channel_pkg;

    localparam int PROD_W_DEF    = 16;
    localparam int ACC_W_DEF     = 24;
    localparam int LEN_W_DEF     = 8;
    localparam int OUT_DEPTH_DEF = 4;

    localparam int FIFO_EMPTY_W = 1;
    localparam int FIFO_RD_EN_W = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        PUSH  = 2'd2
    } accum_state_e;

endpackage

// File: rtl/channel_sum_fifo.sv
// First-word-fall-through result FIFO for completed row sums.
// Reads when empty and writes when full are ignored.
module channel_sum_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/channel_row_accum.sv
// Sums Channel products per row and queues row sums for the result writer.
// Define CHANNEL_ACC_SAT_EN for saturating (instead of wrapping) accumulation.
module channel_row_accum
    import channel_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int OUT_DEPTH = OUT_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] mult_out,
    input  logic              mult_empty,
    output logic              mult_rd_en,
    input  logic [LEN_W-1:0]  row_len,
    input  logic              row_len_empty,
    output logic              row_len_rd_en,
    output logic [ACC_W-1:0]  sum_out,
    output logic              sum_empty,
    input  logic              sum_rd_en,
    output logic [15:0]       rows_done
);

    accum_state_e     state;
    accum_state_e     state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_add;
    logic [LEN_W-1:0] remaining;
    logic             push;
    logic             full;

`ifdef CHANNEL_ACC_SAT_EN
    logic [ACC_W:0] acc_sum;

    // Once pinned at all ones, further adds keep overflowing and stay pinned.
    assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(mult_out);
    assign acc_add = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
`else
    assign acc_add = acc + ACC_W'(mult_out);
`endif

    always_comb begin
        state_next    = state;
        mult_rd_en    = 1'b0;
        row_len_rd_en = 1'b0;
        push          = 1'b0;
        unique case (state)
            IDLE: begin
                row_len_rd_en = !row_len_empty && !rst;
                if (row_len_rd_en) begin
                    state_next = (row_len == '0) ? PUSH : ACCUM;
                end
            end
            ACCUM: begin
                mult_rd_en = !mult_empty && !rst;
                if (mult_rd_en && remaining == LEN_W'(1)) begin
                    state_next = PUSH;
                end
            end
            PUSH: begin
                push = !full;
                if (push) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            rows_done <= '0;
        end else begin
            state <= state_next;
            if (row_len_rd_en) begin
                acc       <= '0;
                remaining <= row_len;
            end
            if (mult_rd_en) begin
                acc       <= acc_add;
                remaining <= remaining - 1'b1;
            end
            if (push) begin
                rows_done <= rows_done + 16'd1;
            end
        end
    end

    channel_sum_fifo #(
        .DEPTH (OUT_DEPTH),
        .W     (ACC_W)
    ) u_sum_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (acc),
        .rd_en   (sum_rd_en),
        .rd_data (sum_out),
        .full    (full),
        .empty   (sum_empty)
    );

endmodule

// File: tb/tb_channel_row_accum.sv
// Directed bench for channel_row_accum with FWFT source models.
// Built with ACC_W=16 so the overflow row exercises the 16-bit wrap/saturate.
module tb_channel_row_accum;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 16;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [PROD_W-1:0] mult_out = '0;
    logic              mult_empty = 1'b1;
    logic              mult_rd_en;
    logic [LEN_W-1:0]  row_len = '0;
    logic              row_len_empty = 1'b1;
    logic              row_len_rd_en;
    logic [ACC_W-1:0]  sum_out;
    logic              sum_empty;
    logic              sum_rd_en = 1'b0;
    logic [15:0]       rows_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PROD_W-1:0] prod_q[$];
    logic [LEN_W-1:0]  len_q[$];
    bit stall = 1'b0;
    bit pm = 1'b0;
    bit pl = 1'b0;
    int mult_pops = 0;
    int len_pops = 0;
    int bad_pop = 0;
    int rst_bad = 0;
    int cyc = 0;
    int last_pop_cyc = 0;

    always #5 clk = ~clk;

    channel_row_accum #(
        .PROD_W    (PROD_W),
        .ACC_W     (ACC_W),
        .LEN_W     (LEN_W),
        .OUT_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mult_out      (mult_out),
        .mult_empty    (mult_empty),
        .mult_rd_en    (mult_rd_en),
        .row_len       (row_len),
        .row_len_empty (row_len_empty),
        .row_len_rd_en (row_len_rd_en),
        .sum_out       (sum_out),
        .sum_empty     (sum_empty),
        .sum_rd_en     (sum_rd_en),
        .rows_done     (rows_done)
    );

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mult_rd_en && mult_empty) bad_pop = bad_pop + 1;
        if (row_len_rd_en && row_len_empty) bad_pop = bad_pop + 1;
        if (rst && (mult_rd_en || row_len_rd_en)) rst_bad = rst_bad + 1;
        pm = mult_rd_en && !mult_empty;
        pl = row_len_rd_en && !row_len_empty;
        if (pm) begin
            mult_pops = mult_pops + 1;
            last_pop_cyc = cyc;
        end
        if (pl) len_pops = len_pops + 1;
    end

    always @(negedge clk) begin
        if (pm) void'(prod_q.pop_front());
        if (pl) void'(len_q.pop_front());
        pm = 1'b0;
        pl = 1'b0;
        mult_empty = stall || (prod_q.size() == 0);
        mult_out = (prod_q.size() != 0) ? prod_q[0] : '0;
        row_len_empty = (len_q.size() == 0);
        row_len = (len_q.size() != 0) ? len_q[0] : '0;
    end

    task automatic wait_sum(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (!sum_empty) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: timeout waiting for sum_empty=0", name);
        end
    endtask

    task automatic read_sum(input string name, input logic [ACC_W-1:0] exp);
        bit ok;
        wait_sum(name, ok);
        if (ok) begin
            n_checks++;
            if (sum_out !== exp) begin
                n_fail++;
                $display("FAIL %s: sum_out=%0h expected %0h", name, sum_out, exp);
            end
        end
        @(negedge clk);
        sum_rd_en = 1'b1;
        @(negedge clk);
        sum_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (sum_empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_empty: got %b expected 1", sum_empty);
        end
        n_checks++;
        if (sum_out !== '0) begin
            n_fail++; $display("FAIL reset_sum: got %0h expected 0", sum_out);
        end
        n_checks++;
        if (rows_done !== 16'd0) begin
            n_fail++; $display("FAIL reset_rows: got %0d expected 0", rows_done);
        end
        n_checks++;
        if (mult_rd_en !== 1'b0 || row_len_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rden: got %b%b expected 00", mult_rd_en, row_len_rd_en);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_row();
        int p0;
        bit ok;
        p0 = mult_pops;
        len_q.push_back(8'd8);
        prod_q.push_back(16'd1); prod_q.push_back(16'd2);
        prod_q.push_back(16'd3); prod_q.push_back(16'd4);
        prod_q.push_back(16'd5); prod_q.push_back(16'd6);
        prod_q.push_back(16'd7); prod_q.push_back(16'd7);
        wait_sum("basic_wait", ok);
        if (ok) begin
            n_checks++;
            if (sum_out !== 16'd35) begin
                n_fail++; $display("FAIL basic_sum: got %0d expected 35", sum_out);
            end
            n_checks++;
            if (cyc !== last_pop_cyc + 1) begin
                n_fail++;
                $display("FAIL basic_latency: write edge %0d expected %0d", cyc, last_pop_cyc + 1);
            end
            n_checks++;
            if (mult_pops - p0 !== 8) begin
                n_fail++; $display("FAIL basic_pops: got %0d expected 8", mult_pops - p0);
            end
            n_checks++;
            if (rows_done !== 16'd1) begin
                n_fail++; $display("FAIL basic_rows: got %0d expected 1", rows_done);
            end
        end
        @(negedge clk);
        sum_rd_en = 1'b1;
        @(negedge clk);
        sum_rd_en = 1'b0;
        #1;
        n_checks++;
        if (sum_empty !== 1'b1) begin
            n_fail++; $display("FAIL basic_drain: sum_empty=%b expected 1", sum_empty);
        end
    endtask

    task automatic test_zero_len();
        int p0;
        bit ok;
        p0 = mult_pops;
        len_q.push_back(8'd0);
        len_q.push_back(8'd2);
        prod_q.push_back(16'd10);
        prod_q.push_back(16'd20);
        wait_sum("zero_wait", ok);
        if (ok) begin
            n_checks++;
            if (sum_out !== 16'd0) begin
                n_fail++; $display("FAIL zero_sum: got %0d expected 0", sum_out);
            end
            n_checks++;
            if (mult_pops !== p0) begin
                n_fail++; $display("FAIL zero_nopop: pops %0d expected 0", mult_pops - p0);
            end
        end
        @(negedge clk);
        sum_rd_en = 1'b1;
        @(negedge clk);
        sum_rd_en = 1'b0;
        read_sum("zero_second", 16'd30);
        n_checks++;
        if (rows_done !== 16'd3) begin
            n_fail++; $display("FAIL zero_rows: got %0d expected 3", rows_done);
        end
    endtask

    task automatic test_stalls();
        int b0;
        bit seen;
        b0 = bad_pop;
        seen = 1'b0;
        len_q.push_back(8'd4);
        repeat (4) prod_q.push_back(16'd100);
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            stall = ~stall;
            #1;
            if (!sum_empty) seen = 1'b1;
        end
        stall = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL stall_done: sum_empty=%b expected 0", sum_empty);
        end else if (sum_out !== 16'd400) begin
            n_fail++; $display("FAIL stall_sum: got %0d expected 400", sum_out);
        end
        n_checks++;
        if (bad_pop !== b0) begin
            n_fail++; $display("FAIL stall_badpop: got %0d expected %0d", bad_pop, b0);
        end
        @(negedge clk);
        sum_rd_en = 1'b1;
        @(negedge clk);
        sum_rd_en = 1'b0;
    endtask

    task automatic test_backpressure();
        int r0;
        int m0;
        int l0;
        r0 = rows_done;
        for (int i = 1; i <= 5; i++) begin
            len_q.push_back(8'd1);
            prod_q.push_back(PROD_W'(i));
        end
        repeat (30) @(negedge clk);
        #1;
        n_checks++;
        if (rows_done !== 16'(r0 + 4)) begin
            n_fail++; $display("FAIL bp_rows4: got %0d expected %0d", rows_done, r0 + 4);
        end
        n_checks++;
        if (mult_pops - m0 < 0 || prod_q.size() != 0 || len_q.size() != 0) begin
            n_fail++; $display("FAIL bp_inputs: prod left %0d len left %0d expected 0", prod_q.size(), len_q.size());
        end
        m0 = mult_pops;
        l0 = len_pops;
        len_q.push_back(8'd1);
        prod_q.push_back(16'd9);
        repeat (6) @(negedge clk);
        #1;
        n_checks++;
        if (mult_pops !== m0 || len_pops !== l0) begin
            n_fail++;
            $display("FAIL bp_hold: pops %0d/%0d expected 0/0", mult_pops - m0, len_pops - l0);
        end
        n_checks++;
        if (sum_out !== 16'd1) begin
            n_fail++; $display("FAIL bp_head: got %0d expected 1", sum_out);
        end
        sum_rd_en = 1'b1;
        @(negedge clk);
        sum_rd_en = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (rows_done !== 16'(r0 + 5)) begin
            n_fail++; $display("FAIL bp_rows5: got %0d expected %0d", rows_done, r0 + 5);
        end
        read_sum("bp_rd2", 16'd2);
        read_sum("bp_rd3", 16'd3);
        read_sum("bp_rd4", 16'd4);
        read_sum("bp_rd5", 16'd5);
        read_sum("bp_rd9", 16'd9);
    endtask

    task automatic test_overflow();
        len_q.push_back(8'd2);
        prod_q.push_back(16'hFFFF);
        prod_q.push_back(16'h0002);
`ifdef CHANNEL_ACC_SAT_EN
        read_sum("overflow", 16'hFFFF);
`else
        read_sum("overflow", 16'h0001);
`endif
    endtask

    task automatic test_reset_mid_row();
        int p0;
        bit got;
        p0 = mult_pops;
        got = 1'b0;
        len_q.push_back(8'd8);
        prod_q.push_back(16'd1);
        prod_q.push_back(16'd2);
        prod_q.push_back(16'd3);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (mult_pops - p0 == 3) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++; $display("FAIL mid_pops: got %0d expected 3", mult_pops - p0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (mult_rd_en !== 1'b0 || row_len_rd_en !== 1'b0 || rst_bad != 0) begin
            n_fail++;
            $display("FAIL mid_rden: %b%b bad=%0d expected 00 0", mult_rd_en, row_len_rd_en, rst_bad);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (sum_empty !== 1'b1) begin
            n_fail++; $display("FAIL mid_empty: got %b expected 1", sum_empty);
        end
        n_checks++;
        if (rows_done !== 16'd0) begin
            n_fail++; $display("FAIL mid_rows: got %0d expected 0", rows_done);
        end
        len_q.push_back(8'd2);
        prod_q.push_back(16'd5);
        prod_q.push_back(16'd6);
        read_sum("mid_after", 16'd11);
    endtask

    initial begin
        test_reset();
        test_basic_row();
        test_zero_len();
        test_stalls();
        test_backpressure();
        test_overflow();
        test_reset_mid_row();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
